// File: rtl/micro80_uart_pkg.sv
// Shared types and constants for the Micro80 UART receiver.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after D7).
`timescale 1ns/1ps
package micro80_uart_pkg;

    // Receiver frame state
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    // Status register bit positions
    localparam int unsigned ST_RDY  = 0;
    localparam int unsigned ST_FULL = 1;
    localparam int unsigned ST_FERR = 2;
    localparam int unsigned ST_OVR  = 3;
    localparam int unsigned ST_PERR = 4;

    // CPU I/O port addresses decoded by the I/O read mux
    localparam logic [7:0] UART_DATA_PORT = 8'hE8;
    localparam logic [7:0] UART_STAT_PORT = 8'hE9;

    // Oversampling divider, rounded to nearest
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned ovs);
        return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO for received bytes; pop is evaluated before push.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic             r_empty;
    logic             r_full;
    logic [WIDTH-1:0] r_dout;

    logic             w_pop;
    logic             w_push;
    logic [PW-1:0]    w_rptr_nxt;
    logic [PW-1:0]    w_wptr_nxt;
    logic             w_empty_nxt;
    logic             w_full_nxt;
    logic [WIDTH-1:0] w_head;

    // Next pointers, flags and next head byte (bypass when writing into an empty slot at the head)
    always_comb begin
        w_pop       = pop && !r_empty;
        w_push      = push && (!r_full || w_pop);
        w_rptr_nxt  = r_rptr + PW'(w_pop);
        w_wptr_nxt  = r_wptr + PW'(w_push);
        w_empty_nxt = (w_rptr_nxt == w_wptr_nxt);
        w_full_nxt  = (w_rptr_nxt[AW] != w_wptr_nxt[AW]) &&
                      (w_rptr_nxt[AW-1:0] == w_wptr_nxt[AW-1:0]);
        if (w_push && (w_rptr_nxt == r_wptr)) begin
            w_head = din;
        end else begin
            w_head = r_mem[w_rptr_nxt[AW-1:0]];
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= din;
        end
    end

    // Pointers, registered flags and head; head holds its value once empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_empty <= w_empty_nxt;
            r_full  <= w_full_nxt;
            if (!w_empty_nxt) begin
                r_dout <= w_head;
            end
        end
    end

    assign dout  = r_dout;
    assign empty = r_empty;
    assign full  = r_full;

endmodule

// File: rtl/uart_rx.sv
// Micro80 UART receiver: 2-FF synchronizer, oversampling tick generator,
// frame FSM and receive FIFO. Data at port 0xE8, status at port 0xE9.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after D7).
`timescale 1ns/1ps
module uart_rx
    import micro80_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVS        = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] dout,
    output logic       rdy,
    output logic [7:0] status
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVS);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OVS_W = $clog2(OVS);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_prev;
    logic [DIV_W-1:0] r_tick_cnt;
    logic [OVS_W-1:0] r_samp_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    rx_state_e        r_state;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_tick;
    logic             w_start;
    logic             w_half_pt;
    logic             w_bit_pt;
    logic             w_push;
    logic             w_set_ferr;
    logic             w_set_ovr;
    logic             w_par_ok;
    logic             w_perr;
    logic             w_fifo_empty;
    logic             w_fifo_full;

`ifdef UART_RX_PARITY_EN
    logic             r_par_ok;
    logic             r_parity_err;
    logic             w_set_perr;

    assign w_set_perr = (r_state == PARITY) && w_bit_pt && ((^r_shift) != r_sync2);
    assign w_par_ok   = r_par_ok;
    assign w_perr     = r_parity_err;
`else
    assign w_par_ok   = 1'b1;
    assign w_perr     = 1'b0;
`endif

    assign w_tick     = (r_tick_cnt == DIV_W'(DIV - 1));
    assign w_start    = (r_state == IDLE) && r_rx_prev && !r_sync2;
    assign w_half_pt  = w_tick && (r_samp_cnt == OVS_W'(OVS / 2 - 1));
    assign w_bit_pt   = w_tick && (r_samp_cnt == OVS_W'(OVS - 1));
    assign w_push     = (r_state == STOP) && w_bit_pt && r_sync2 && w_par_ok;
    assign w_set_ferr = (r_state == STOP) && w_bit_pt && !r_sync2;
    assign w_set_ovr  = w_push && w_fifo_full && !rd;

    // Two-flop synchronizer plus previous value for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Free-running oversample tick divider, realigned on a start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (w_start || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + DIV_W'(1);
        end
    end

    // Frame FSM: start validation, LSB-first data shift, optional parity, stop check
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_samp_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_ok   <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_samp_cnt <= '0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_half_pt) begin
                        r_samp_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= r_sync2 ? IDLE : DATA;
                    end else if (w_tick) begin
                        r_samp_cnt <= r_samp_cnt + OVS_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_pt) begin
                        r_samp_cnt <= '0;
                        r_shift    <= {r_sync2, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end else if (w_tick) begin
                        r_samp_cnt <= r_samp_cnt + OVS_W'(1);
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (w_bit_pt) begin
                        r_samp_cnt <= '0;
                        r_par_ok   <= ((^r_shift) == r_sync2);
                        r_state    <= STOP;
                    end else if (w_tick) begin
                        r_samp_cnt <= r_samp_cnt + OVS_W'(1);
                    end
`else
                    r_state <= IDLE;
`endif
                end
                STOP: begin
                    if (w_bit_pt) begin
                        r_samp_cnt <= '0;
                        r_state    <= r_sync2 ? IDLE : BREAK;
                    end else if (w_tick) begin
                        r_samp_cnt <= r_samp_cnt + OVS_W'(1);
                    end
                end
                BREAK: begin
                    if (r_sync2) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky error bits; a new error wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            if (w_set_ferr)   r_frame_err <= 1'b1;
            else if (clr_err) r_frame_err <= 1'b0;
            if (w_set_ovr)    r_overrun   <= 1'b1;
            else if (clr_err) r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (w_set_perr)   r_parity_err <= 1'b1;
            else if (clr_err) r_parity_err <= 1'b0;
`endif
        end
    end

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (r_shift),
        .pop   (rd),
        .dout  (dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    assign rdy = !w_fifo_empty;

    // Status byte assembled from flag registers
    always_comb begin
        status          = 8'h00;
        status[ST_RDY]  = !w_fifo_empty;
        status[ST_FULL] = w_fifo_full;
        status[ST_FERR] = r_frame_err;
        status[ST_OVR]  = r_overrun;
        status[ST_PERR] = w_perr;
    end

endmodule
